// File: rtl/lfsr_seq_checker_if.sv
// lfsr_seq_checker_if: sample strobe, LFSR bus and health/statistics outputs of the sequence checker.
interface lfsr_seq_checker_if #(parameter int CNT_W = 16);
  logic             write_Enable;
  logic [31:0]      seq_in;
  logic             clear_stats;
  logic             locked;
  logic             seq_err;
  logic             illegal;
  logic [CNT_W-1:0] err_count;
  logic [CNT_W-1:0] match_count;
  modport master (
    output write_Enable, seq_in, clear_stats,
    input  locked, seq_err, illegal, err_count, match_count
  );
  modport slave (
    input  write_Enable, seq_in, clear_stats,
    output locked, seq_err, illegal, err_count, match_count
  );
endinterface

// File: rtl/lfsr_seq_checker.sv
// lfsr_seq_checker: locks onto the 6-bit XNOR LFSR stream by confirming predictions, then flags and counts sequence errors.
module lfsr_seq_checker #(
  parameter int LOCK_THRESH = 4,
  parameter int LOSS_THRESH = 3,
  parameter int CNT_W       = 16
) (
  input logic               clk,
  input logic               aclr,
  lfsr_seq_checker_if.slave bus
);
  typedef enum logic [1:0] {SEARCH, VERIFY, LOCK} state_t;
  state_t           state_q, state_d;
  logic [5:0]       pred_q, pred_d, v;
  logic [3:0]       streak_q, streak_d, miss_q, miss_d;
  logic             seq_err_q, seq_err_d, illegal_q, illegal_d, locked_q, locked_d;
  logic [CNT_W-1:0] err_q, err_d, match_q, match_d;
  logic             ill, hit, err_inc, match_inc;
  function automatic logic [5:0] nxt(input logic [5:0] s);
    return {s[4:0], ~(s[5] ^ s[0])};
  endfunction
  always_comb begin
    v         = bus.seq_in[5:0];
    ill       = (|bus.seq_in[31:6]) || (&v);
    hit       = !ill && (v == pred_q);
    state_d   = state_q;
    pred_d    = pred_q;
    streak_d  = streak_q;
    miss_d    = miss_q;
    seq_err_d = 1'b0;
    illegal_d = 1'b0;
    err_inc   = 1'b0;
    match_inc = 1'b0;
    if (bus.write_Enable) begin
      illegal_d = ill;
      case (state_q)
        SEARCH: begin
          if (!ill) begin
            pred_d   = nxt(v);
            streak_d = 4'd0;
            state_d  = VERIFY;
          end
        end
        VERIFY: begin
          if (ill) state_d = SEARCH;
          else begin
            pred_d   = nxt(v);
            streak_d = hit ? streak_q + 4'd1 : 4'd0;
            if (hit && streak_d == 4'(LOCK_THRESH)) begin
              state_d = LOCK;
              miss_d  = 4'd0;
            end
          end
        end
        LOCK: begin
          // flywheel: once locked, keep predicting from our own state rather than reseeding on bad data
          pred_d    = nxt(pred_q);
          match_inc = hit;
          err_inc   = !hit;
          seq_err_d = !hit;
          miss_d    = hit ? 4'd0 : miss_q + 4'd1;
          if (!hit && miss_d == 4'(LOSS_THRESH)) state_d = SEARCH;
        end
        default: state_d = SEARCH;
      endcase
    end
    locked_d = (state_d == LOCK);
    err_d    = bus.clear_stats ? '0 : (err_inc && !(&err_q)) ? err_q + CNT_W'(1) : err_q;
    match_d  = bus.clear_stats ? '0 : (match_inc && !(&match_q)) ? match_q + CNT_W'(1) : match_q;
  end
  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      state_q   <= SEARCH;
      pred_q    <= '0;
      streak_q  <= '0;
      miss_q    <= '0;
      seq_err_q <= 1'b0;
      illegal_q <= 1'b0;
      locked_q  <= 1'b0;
      err_q     <= '0;
      match_q   <= '0;
    end else begin
      state_q   <= state_d;
      pred_q    <= pred_d;
      streak_q  <= streak_d;
      miss_q    <= miss_d;
      seq_err_q <= seq_err_d;
      illegal_q <= illegal_d;
      locked_q  <= locked_d;
      err_q     <= err_d;
      match_q   <= match_d;
    end
  end
  assign bus.locked      = locked_q;
  assign bus.seq_err     = seq_err_q;
  assign bus.illegal     = illegal_q;
  assign bus.err_count   = err_q;
  assign bus.match_count = match_q;
endmodule

// File: tb/tb_lfsr_seq_checker.sv
// tb_lfsr_seq_checker: directed vector table, randomized run against a behavioural model, and saturation/clear/reset corners.
module tb_lfsr_seq_checker;
  logic clk = 1'b0;
  logic aclr = 1'b0;
  always #5 clk = ~clk;
  lfsr_seq_checker_if #(.CNT_W(16)) bus ();
  lfsr_seq_checker_if #(.CNT_W(4))  sbus ();
  assign sbus.write_Enable = bus.write_Enable;
  assign sbus.seq_in       = bus.seq_in;
  assign sbus.clear_stats  = bus.clear_stats;
  lfsr_seq_checker dut (.clk(clk), .aclr(aclr), .bus(bus));
  lfsr_seq_checker #(.CNT_W(4)) dut_s (.clk(clk), .aclr(aclr), .bus(sbus));
  int total = 0;
  int bad = 0;
  typedef struct {
    bit          rst;
    bit          we;
    logic [31:0] d;
    bit          lk, se, il;
    int          ec, mc;
  } vec_t;
  vec_t tbl[$];
  int         m_mode, m_streak, m_miss, m_ec, m_mc;
  logic [5:0] m_pred;
  bit         e_lock, e_err, e_ill;
  logic [5:0] g;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask
  function automatic logic [5:0] nx(input logic [5:0] s);
    int x = int'(s);
    return 6'((x * 2) % 64 + (((x / 32) + x) % 2 == 0 ? 1 : 0));
  endfunction
  function automatic int sat(input int x, input int m);
    return x > m ? m : x;
  endfunction
  function automatic vec_t mk(input bit rst, input logic [31:0] d, input bit lk, input bit se,
                              input bit il, input int ec, input int mc, input bit we = 1'b1);
    vec_t r;
    r.rst = rst; r.we = we; r.d = d; r.lk = lk; r.se = se; r.il = il; r.ec = ec; r.mc = mc;
    return r;
  endfunction
  task automatic model_reset();
    m_mode = 0; m_streak = 0; m_miss = 0; m_ec = 0; m_mc = 0; m_pred = '0;
    e_lock = 0; e_err = 0; e_ill = 0;
  endtask
  // mode 0 = hunting for a seed, 1 = confirming predictions, 2 = locked
  task automatic model_step(input bit we, input logic [31:0] d, input bit clr);
    bit ill, ok;
    logic [5:0] val;
    ill = (d[31:6] != 0) || (d[5:0] == 6'h3F);
    val = d[5:0];
    e_err = 0;
    e_ill = 0;
    if (we) begin
      e_ill = ill;
      if (m_mode == 0) begin
        if (!ill) begin m_pred = nx(val); m_streak = 0; m_mode = 1; end
      end else if (m_mode == 1) begin
        if (ill) m_mode = 0;
        else if (val == m_pred) begin
          m_streak++;
          m_pred = nx(val);
          if (m_streak == 4) begin m_mode = 2; m_miss = 0; end
        end else begin
          m_pred = nx(val);
          m_streak = 0;
        end
      end else begin
        ok = !ill && (val == m_pred);
        m_pred = nx(m_pred);
        if (ok) begin m_miss = 0; m_mc++; end
        else begin
          e_err = 1; m_ec++; m_miss++;
          if (m_miss == 3) m_mode = 0;
        end
      end
    end
    if (clr) begin m_ec = 0; m_mc = 0; end
    e_lock = (m_mode == 2);
  endtask
  task automatic do_reset();
    aclr = 1'b0;
    bus.write_Enable = 1'b0;
    bus.seq_in = '0;
    bus.clear_stats = 1'b0;
    #1;
    chk("rst_locked", 32'(bus.locked), 0);
    chk("rst_seq_err", 32'(bus.seq_err), 0);
    chk("rst_illegal", 32'(bus.illegal), 0);
    chk("rst_err_count", 32'(bus.err_count), 0);
    chk("rst_match_count", 32'(bus.match_count), 0);
    model_reset();
    @(negedge clk);
    aclr = 1'b1;
  endtask
  task automatic cyc(input bit we, input logic [31:0] d, input bit clr);
    bus.write_Enable = we;
    bus.seq_in = d;
    bus.clear_stats = clr;
    @(posedge clk);
    #1;
    model_step(we, d, clr);
    chk("locked", 32'(bus.locked), 32'(e_lock));
    chk("seq_err", 32'(bus.seq_err), 32'(e_err));
    chk("illegal", 32'(bus.illegal), 32'(e_ill));
    chk("err_count", 32'(bus.err_count), sat(m_ec, 65535));
    chk("match_count", 32'(bus.match_count), sat(m_mc, 65535));
    chk("small_err_count", 32'(sbus.err_count), sat(m_ec, 15));
    chk("small_match_count", 32'(sbus.match_count), sat(m_mc, 15));
  endtask
  initial begin
    bus.write_Enable = 1'b0;
    bus.seq_in = '0;
    bus.clear_stats = 1'b0;
    // lock, then matches
    tbl.push_back(mk(1, 32'h00, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 32'h01, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 32'h02, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 32'h05, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 32'h0A, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 32'h15, 1, 0, 0, 0, 1));
    tbl.push_back(mk(0, 32'h2A, 1, 0, 0, 0, 2));
    tbl.push_back(mk(0, 32'h14, 1, 0, 0, 0, 3));
    tbl.push_back(mk(0, 32'h3F, 1, 0, 0, 0, 3, 1'b0));
    // three consecutive errors drop lock
    tbl.push_back(mk(0, 32'h00,  1, 1, 0, 1, 3));
    tbl.push_back(mk(0, 32'h100, 1, 1, 1, 2, 3));
    tbl.push_back(mk(0, 32'h00,  0, 1, 0, 3, 3));
    // single error then resume on the flywheel prediction
    tbl.push_back(mk(1, 32'h00, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 32'h01, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 32'h02, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 32'h05, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 32'h0A, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 32'h33, 1, 1, 0, 1, 0));
    tbl.push_back(mk(0, 32'h2A, 1, 0, 0, 1, 1));
    // illegal words in VERIFY fall back to SEARCH
    tbl.push_back(mk(1, 32'h00, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 32'h01, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 32'h40, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 32'h00, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 32'h01, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 32'h3F, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 32'h00, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 32'h01, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 32'h02, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 32'h05, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 32'h0A, 1, 0, 0, 0, 0));
    foreach (tbl[i]) begin
      if (tbl[i].rst) do_reset();
      bus.write_Enable = tbl[i].we;
      bus.seq_in = tbl[i].d;
      bus.clear_stats = 1'b0;
      @(posedge clk);
      #1;
      chk($sformatf("row%0d_locked", i), 32'(bus.locked), 32'(tbl[i].lk));
      chk($sformatf("row%0d_seq_err", i), 32'(bus.seq_err), 32'(tbl[i].se));
      chk($sformatf("row%0d_illegal", i), 32'(bus.illegal), 32'(tbl[i].il));
      chk($sformatf("row%0d_err_count", i), 32'(bus.err_count), tbl[i].ec);
      chk($sformatf("row%0d_match_count", i), 32'(bus.match_count), tbl[i].mc);
    end
    do_reset();
    g = 6'h00;
    for (int n = 0; n < 3000; n++) begin
      int p;
      bit we;
      logic [31:0] d;
      we = $urandom_range(0, 99) >= 8;
      p = $urandom_range(0, 99);
      d = p < 80 ? {26'd0, g} : p < 90 ? 32'($urandom_range(0, 62)) : p < 95 ? 32'($urandom) : 32'h3F;
      if (!we) d = 32'($urandom);
      cyc(we, d, we && $urandom_range(0, 49) == 0);
      if (we) g = nx(g);
    end
    do_reset();
    cyc(1, 32'h0A, 0);
    repeat (4) cyc(1, {26'd0, m_pred}, 0);
    chk("sat_locked", 32'(bus.locked), 1);
    repeat (8) begin
      cyc(1, {26'd0, m_pred ^ 6'h01}, 0);
      cyc(1, {26'd0, m_pred ^ 6'h01}, 0);
      cyc(1, {26'd0, m_pred}, 0);
    end
    chk("sat_small_ec", 32'(sbus.err_count), 15);
    chk("sat_big_ec", 32'(bus.err_count), 16);
    chk("sat_small_mc", 32'(sbus.match_count), 8);
    cyc(1, {26'd0, m_pred ^ 6'h01}, 0);
    chk("sat_small_ec_hold", 32'(sbus.err_count), 15);
    cyc(1, {26'd0, m_pred ^ 6'h01}, 1);
    chk("clr_err_ec", 32'(bus.err_count), 0);
    chk("clr_err_pulse", 32'(bus.seq_err), 1);
    chk("clr_locked", 32'(bus.locked), 1);
    cyc(1, {26'd0, m_pred}, 0);
    chk("mid_lock_before_rst", 32'(bus.locked), 1);
    do_reset();
    cyc(1, 32'h00, 0);
    chk("after_rst_locked", 32'(bus.locked), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/lfsr_seq_checker.md
Name: lfsr_seq_checker

Overview:
Receive-side checker for the 6-bit XNOR LFSR obstacle/terrain sequence generator. It sits on the generator's 32-bit output bus and samples it on the same enable strobe. It self-synchronises to the stream by predicting each next value and confirming the predictions. Once locked, it flags and counts sequence errors, giving the game logic and the bench a health indication for the random source.

Parameters:
- LOCK_THRESH, 4: consecutive correct predictions required to go VERIFY -> LOCK (range 1..15).
- LOSS_THRESH, 3: consecutive errors in LOCK that force a return to SEARCH (range 1..15).
- CNT_W, 16: width of the error and match counters.

Ports:
- clk, input, 1: rising-edge clock, shared with the generator.
- aclr, input, 1: reset; asynchronous, active-low. Low clears all state immediately.
- write_Enable, input, 1: sample strobe. The bus is sampled only when high.
- seq_in, input, 32: generator output bus. Bits [5:0] carry the value; bits [31:6] must be 0.
- clear_stats, input, 1: synchronous clear of err_count and match_count only.
- locked, output, 1: high while in LOCK.
- seq_err, output, 1: one-cycle pulse on each error detected in LOCK.
- illegal, output, 1: one-cycle pulse on any sampled illegal word.
- err_count, output, CNT_W: errors detected in LOCK; saturating.
- match_count, output, CNT_W: correct predictions in LOCK; saturating.

Behaviour:
- Prediction function: nxt(s) = {s[4:0], ~(s[5]^s[0])}.
- Illegal word: seq_in[31:6] != 0, or seq_in[5:0] == 6'h3F (the lockup state, which the generator never presents stably).
- Reset (aclr low): state = SEARCH; pred, streak and miss = 0; all outputs 0.
- State changes occur only on a clk edge with write_Enable = 1. When write_Enable = 0, all state holds and the pulse outputs are 0.
- All outputs are registered. Each response appears in the cycle after the sampling edge.
- SEARCH:
  - Legal sample v: pred <= nxt(v), streak <= 0, go to VERIFY.
  - Illegal sample: stay in SEARCH, pulse illegal.
- VERIFY:
  - Sample == pred: pred <= nxt(sample), streak++. When the new streak == LOCK_THRESH, go to LOCK with miss <= 0.
  - Legal mismatch: reseed, pred <= nxt(sample), streak <= 0, stay in VERIFY.
  - Illegal sample: go to SEARCH, pulse illegal.
- LOCK:
  - Match: pred <= nxt(pred), miss <= 0, match_count++.
  - Mismatch or illegal sample: pulse seq_err (plus illegal if applicable), err_count++, pred <= nxt(pred) (flywheel: keep predicting, do not reseed), miss++. When the new miss == LOSS_THRESH, go to SEARCH.
- Counters saturate at all-ones and do not wrap.
- clear_stats takes priority over an increment in the same cycle: the counter goes to 0 and the increment is dropped. State and locked are unaffected.
- locked = (state == LOCK), registered.
- An aclr assertion mid-stream aborts immediately. The next legal sample after release starts SEARCH.

Test Plan:
1. Reset, then strobe 00,01,02,05,0A -> locked = 1 the cycle after the 0x0A sample; err_count = 0.
2. Locked (case 1), continue with 15,2A,14 -> match_count = 3, no seq_err.
3. Locked, predicted value 0x15, inject 0x33, then resume with 0x2A -> one seq_err pulse, err_count = 1, locked stays 1, match resumes on 0x2A.
4. Locked, inject 3 consecutive wrong values -> 3 seq_err pulses, err_count = 3, locked = 0 after the third.
5. In VERIFY, sample 32'h0000_0040 or 6'h3F -> illegal pulse, state = SEARCH, locked stays 0. Then 0x00 -> re-enters VERIFY.
6. Drive err_count to 16'hFFFF (force or long run) plus one more error -> stays 0xFFFF. Assert clear_stats together with an error -> err_count = 0. Assert aclr mid-LOCK -> all outputs 0 asynchronously.
